// File: rtl/exu_alu_dpath_arb.sv
// -----------------------------------------------------------------------------
// exu_alu_dpath_arb
//
// Arbiter and sequencer for the shared, purely combinational ALU datapath.
// Four requesters (ALU, BJP, AGU, MULDIV) compete for the datapath. At most
// one of them is granted per cycle, with zero-cycle latency, because the
// datapath result is consumed in the same cycle as the grant.
//
// AGU and MULDIV may lock the datapath across several beats, for AMO
// sequences and divide iterations respectively. A watchdog forces a lock to
// release after LOCK_TIMEOUT consecutive locked cycles.
//
// Parameters
//   LOCK_TIMEOUT   locked cycles before a forced release (2..255)
//   CNT_W          watchdog counter width, 2**CNT_W > LOCK_TIMEOUT
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   <req>_arb_vld / _arb_rdy     request / grant per requester (vld & rdy)
//   agu_arb_lock, muldiv_arb_lock  keep the datapath after this beat
//   <req>_req_alu                one-hot datapath selects (equal to rdy)
//   arb_owner                    index of the last granted requester
//                                (0 ALU, 1 BJP, 2 AGU, 3 MULDIV)
//   arb_locked                   registered lock state
//   lock_tmo_err / lock_tmo_clr  sticky watchdog flag and its clear
// -----------------------------------------------------------------------------
module exu_alu_dpath_arb #(
   parameter int LOCK_TIMEOUT = 64,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_arb_vld,
   output logic       alu_arb_rdy,
   input  logic       bjp_arb_vld,
   output logic       bjp_arb_rdy,
   input  logic       agu_arb_vld,
   input  logic       agu_arb_lock,
   output logic       agu_arb_rdy,
   input  logic       muldiv_arb_vld,
   input  logic       muldiv_arb_lock,
   output logic       muldiv_arb_rdy,
   output logic       alu_req_alu,
   output logic       bjp_req_alu,
   output logic       agu_req_alu,
   output logic       muldiv_req_alu,
   output logic [1:0] arb_owner,
   output logic       arb_locked,
   output logic       lock_tmo_err,
   input  logic       lock_tmo_clr
);

   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(LOCK_TIMEOUT);

   logic [0:0]       state_reg,      state_next;
   logic [1:0]       rr_ptr_reg,     rr_ptr_next;
   logic [1:0]       lock_owner_reg, lock_owner_next;
   logic [CNT_W-1:0] lock_cnt_reg,   lock_cnt_next;
   logic [1:0]       arb_owner_reg,  arb_owner_next;
   logic             tmo_err_reg,    tmo_err_next;

   logic [3:0] vld_vec;
   logic [3:0] lock_vec;
   logic [3:0] gnt_vec;
   logic [1:0] pick_idx;
   logic       pick_vld;
   logic [1:0] grant_idx;
   logic       grant_vld;
   logic       grant_lock;
   logic       tmo_hit;

   assign vld_vec  = {muldiv_arb_vld, agu_arb_vld, bjp_arb_vld, alu_arb_vld};
   // ALU and BJP have no lock input, so they can never enter LOCKED.
   assign lock_vec = {muldiv_arb_lock, agu_arb_lock, 2'b00};

   // Round-robin search starting at rr_ptr. Iterating from the farthest
   // candidate down to the nearest lets the nearest valid requester win.
   always_comb begin
      logic [1:0] idx;
      pick_idx = 2'd0;
      pick_vld = 1'b0;
      idx      = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         idx = rr_ptr_reg + 2'(k);
         if (vld_vec[idx]) begin
            pick_idx = idx;
            pick_vld = 1'b1;
         end
      end
   end

   // While locked only the owner may be granted; a missing owner vld is a
   // stall bubble and simply produces no grant.
   always_comb begin
      if (state_reg == ST_LOCKED) begin
         grant_idx = lock_owner_reg;
         grant_vld = vld_vec[lock_owner_reg];
      end else begin
         grant_idx = pick_idx;
         grant_vld = pick_vld;
      end
   end

   // The lock input is only consulted once a grant exists, so rdy never
   // depends on the requester's own lock.
   assign grant_lock = grant_vld & lock_vec[grant_idx];
   assign tmo_hit    = (state_reg == ST_LOCKED) && (lock_cnt_reg >= TMO_CNT);

   // One-hot grant vector; held low while reset is asserted.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
         assign gnt_vec[gi] = grant_vld & (grant_idx == 2'(gi)) & ~rst;
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      rr_ptr_next     = rr_ptr_reg;
      lock_owner_next = lock_owner_reg;
      lock_cnt_next   = lock_cnt_reg;
      arb_owner_next  = arb_owner_reg;
      tmo_err_next    = tmo_err_reg;

      if (grant_vld) begin
         arb_owner_next = grant_idx;
      end

      if (state_reg == ST_ARB) begin
         if (grant_lock) begin
            // rr_ptr advances only when the locked sequence ends.
            state_next      = ST_LOCKED;
            lock_owner_next = grant_idx;
            lock_cnt_next   = CNT_W'(1);
         end else if (grant_vld) begin
            rr_ptr_next = grant_idx + 2'd1;
         end
      end else begin
         if (tmo_hit) begin
            // Forced release: a grant on this cycle is the final beat even
            // if the owner still asks to keep the lock.
            state_next    = ST_ARB;
            rr_ptr_next   = lock_owner_reg + 2'd1;
            lock_cnt_next = '0;
            tmo_err_next  = 1'b1;
         end else if (grant_vld && !grant_lock) begin
            state_next    = ST_ARB;
            rr_ptr_next   = lock_owner_reg + 2'd1;
            lock_cnt_next = '0;
         end else begin
            lock_cnt_next = lock_cnt_reg + CNT_W'(1);
         end
      end

      // A new timeout wins over a simultaneous clear.
      if (lock_tmo_clr && !(tmo_hit)) begin
         tmo_err_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_ARB;
         rr_ptr_reg     <= 2'd0;
         lock_owner_reg <= 2'd0;
         lock_cnt_reg   <= '0;
         arb_owner_reg  <= 2'd0;
         tmo_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         rr_ptr_reg     <= rr_ptr_next;
         lock_owner_reg <= lock_owner_next;
         lock_cnt_reg   <= lock_cnt_next;
         arb_owner_reg  <= arb_owner_next;
         tmo_err_reg    <= tmo_err_next;
      end
   end

   assign alu_arb_rdy    = gnt_vec[0];
   assign bjp_arb_rdy    = gnt_vec[1];
   assign agu_arb_rdy    = gnt_vec[2];
   assign muldiv_arb_rdy = gnt_vec[3];

   assign alu_req_alu    = gnt_vec[0];
   assign bjp_req_alu    = gnt_vec[1];
   assign agu_req_alu    = gnt_vec[2];
   assign muldiv_req_alu = gnt_vec[3];

   assign arb_owner    = arb_owner_reg;
   assign arb_locked   = (state_reg == ST_LOCKED);
   assign lock_tmo_err = tmo_err_reg;

endmodule

// File: tb/tb_exu_alu_dpath_arb.sv
module tb_exu_alu_dpath_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance 0: default LOCK_TIMEOUT
   logic       rst0 = 1'b1;
   logic       alu0 = 0, bjp0 = 0, agu0 = 0, agul0 = 0, md0 = 0, mdl0 = 0, clr0 = 0;
   logic       alu_rdy0, bjp_rdy0, agu_rdy0, md_rdy0;
   logic       alu_sel0, bjp_sel0, agu_sel0, md_sel0;
   logic [1:0] owner0;
   logic       locked0, err0;

   // Instance 1: LOCK_TIMEOUT = 4
   logic       rst1 = 1'b1;
   logic       alu1 = 0, bjp1 = 0, agu1 = 0, agul1 = 0, md1 = 0, mdl1 = 0, clr1 = 0;
   logic       alu_rdy1, bjp_rdy1, agu_rdy1, md_rdy1;
   logic       alu_sel1, bjp_sel1, agu_sel1, md_sel1;
   logic [1:0] owner1;
   logic       locked1, err1;

   exu_alu_dpath_arb dut0 (
      .clk(clk), .rst(rst0),
      .alu_arb_vld(alu0), .alu_arb_rdy(alu_rdy0),
      .bjp_arb_vld(bjp0), .bjp_arb_rdy(bjp_rdy0),
      .agu_arb_vld(agu0), .agu_arb_lock(agul0), .agu_arb_rdy(agu_rdy0),
      .muldiv_arb_vld(md0), .muldiv_arb_lock(mdl0), .muldiv_arb_rdy(md_rdy0),
      .alu_req_alu(alu_sel0), .bjp_req_alu(bjp_sel0),
      .agu_req_alu(agu_sel0), .muldiv_req_alu(md_sel0),
      .arb_owner(owner0), .arb_locked(locked0),
      .lock_tmo_err(err0), .lock_tmo_clr(clr0)
   );

   exu_alu_dpath_arb #(.LOCK_TIMEOUT(4), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst1),
      .alu_arb_vld(alu1), .alu_arb_rdy(alu_rdy1),
      .bjp_arb_vld(bjp1), .bjp_arb_rdy(bjp_rdy1),
      .agu_arb_vld(agu1), .agu_arb_lock(agul1), .agu_arb_rdy(agu_rdy1),
      .muldiv_arb_vld(md1), .muldiv_arb_lock(mdl1), .muldiv_arb_rdy(md_rdy1),
      .alu_req_alu(alu_sel1), .bjp_req_alu(bjp_sel1),
      .agu_req_alu(agu_sel1), .muldiv_req_alu(md_sel1),
      .arb_owner(owner1), .arb_locked(locked1),
      .lock_tmo_err(err1), .lock_tmo_clr(clr1)
   );

   wire [3:0] rdy0 = {md_rdy0, agu_rdy0, bjp_rdy0, alu_rdy0};
   wire [3:0] sel0 = {md_sel0, agu_sel0, bjp_sel0, alu_sel0};
   wire [3:0] rdy1 = {md_rdy1, agu_rdy1, bjp_rdy1, alu_rdy1};

   // Apply one cycle of inputs to instance 0 after the falling edge, then
   // settle so combinational grants can be sampled before the rising edge.
   task automatic drv0(input logic a, input logic b, input logic g, input logic gl,
                       input logic m, input logic ml);
      @(negedge clk);
      alu0 = a; bjp0 = b; agu0 = g; agul0 = gl; md0 = m; mdl0 = ml;
      #1;
      $display("dut0 t=%0t vld=%b%b%b%b rdy=%b owner=%0d locked=%b err=%b",
               $time, m, g, b, a, rdy0, owner0, locked0, err0);
   endtask

   task automatic drv1(input logic a, input logic m, input logic ml, input logic c);
      @(negedge clk);
      alu1 = a; md1 = m; mdl1 = ml; clr1 = c;
      #1;
      $display("dut1 t=%0t alu=%b md=%b lock=%b clr=%b rdy=%b locked=%b err=%b",
               $time, a, m, ml, c, rdy1, locked1, err1);
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst0 = 1'b1; rst1 = 1'b1;
      alu0 = 1; bjp0 = 1; agu0 = 1; md0 = 1;
      #1;
      checks++;
      if (rdy0 !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b want 0000", rdy0); end
      checks++;
      if (owner0 !== 2'd0 || locked0 !== 1'b0 || err0 !== 1'b0) begin
         errors++; $display("FAIL reset_regs got owner=%0d locked=%b err=%b want 0 0 0", owner0, locked0, err0);
      end
      checks++;
      if (dut0.rr_ptr_reg !== 2'd0 || dut0.lock_cnt_reg !== 8'd0) begin
         errors++; $display("FAIL reset_ptr got rr=%0d cnt=%0d want 0 0", dut0.rr_ptr_reg, dut0.lock_cnt_reg);
      end
      @(negedge clk);
      alu0 = 0; bjp0 = 0; agu0 = 0; md0 = 0;
      rst0 = 1'b0; rst1 = 1'b0;
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int c = 0; c < 5; c++) begin
         drv0(1, 1, 1, 0, 1, 0);
         checks++;
         if (rdy0 !== (4'b0001 << exp_seq[c])) begin
            errors++; $display("FAIL rr_grant cyc=%0d got %b want %b", c, rdy0, 4'b0001 << exp_seq[c]);
         end
         checks++;
         if (sel0 !== rdy0) begin errors++; $display("FAIL rr_sel cyc=%0d got %b want %b", c, sel0, rdy0); end
         if (c > 0) begin
            checks++;
            if (owner0 !== exp_seq[c-1]) begin
               errors++; $display("FAIL rr_owner cyc=%0d got %0d want %0d", c, owner0, exp_seq[c-1]);
            end
         end
      end
      // AGU alone, no lock: moves rr_ptr to 3 for the next scenario
      drv0(0, 0, 1, 0, 0, 0);
      checks++;
      if (rdy0 !== 4'b0100) begin errors++; $display("FAIL agu_single got %b want 0100", rdy0); end
   endtask

   task automatic test_muldiv_lock;
      for (int c = 1; c <= 34; c++) begin
         drv0(1, 0, 0, 0, 1, (c < 34));
         checks++;
         if (rdy0 !== 4'b1000) begin errors++; $display("FAIL md_lock_rdy cyc=%0d got %b want 1000", c, rdy0); end
         checks++;
         if (locked0 !== (c >= 2)) begin
            errors++; $display("FAIL md_locked cyc=%0d got %b want %b", c, locked0, (c >= 2));
         end
      end
      drv0(1, 0, 0, 0, 0, 0);
      checks++;
      if (rdy0 !== 4'b0001) begin errors++; $display("FAIL md_after got %b want 0001", rdy0); end
      checks++;
      if (locked0 !== 1'b0 || owner0 !== 2'd3) begin
         errors++; $display("FAIL md_after_state got locked=%b owner=%0d want 0 3", locked0, owner0);
      end
   endtask

   task automatic test_agu_bubble;
      drv0(0, 0, 1, 1, 0, 0);
      checks++;
      if (rdy0 !== 4'b0100) begin errors++; $display("FAIL agu_lock_start got %b want 0100", rdy0); end
      drv0(0, 1, 1, 1, 0, 0);
      checks++;
      if (rdy0 !== 4'b0100) begin errors++; $display("FAIL agu_lock_beat got %b want 0100", rdy0); end
      for (int c = 0; c < 3; c++) begin
         drv0(0, 1, 0, 1, 0, 0);
         checks++;
         if (rdy0 !== 4'b0000 || locked0 !== 1'b1) begin
            errors++; $display("FAIL agu_bubble cyc=%0d got rdy=%b locked=%b want 0000 1", c, rdy0, locked0);
         end
         if (c == 0) begin
            checks++;
            if (dut0.lock_cnt_reg !== 8'd2) begin
               errors++; $display("FAIL agu_cnt_pre got %0d want 2", dut0.lock_cnt_reg);
            end
         end
      end
      drv0(0, 1, 1, 0, 1, 0);
      checks++;
      if (dut0.lock_cnt_reg !== 8'd5) begin errors++; $display("FAIL agu_cnt_post got %0d want 5", dut0.lock_cnt_reg); end
      checks++;
      if (rdy0 !== 4'b0100) begin errors++; $display("FAIL agu_final got %b want 0100", rdy0); end
      drv0(0, 1, 0, 0, 1, 0);
      checks++;
      if (rdy0 !== 4'b1000 || locked0 !== 1'b0) begin
         errors++; $display("FAIL agu_next got rdy=%b locked=%b want 1000 0", rdy0, locked0);
      end
      drv0(1, 1, 0, 0, 0, 0);
      checks++;
      if (rdy0 !== 4'b0001) begin errors++; $display("FAIL agu_wrap got %b want 0001", rdy0); end
   endtask

   task automatic test_single_bjp;
      for (int c = 0; c < 5; c++) begin
         drv0(0, 1, 0, 0, 0, 0);
         checks++;
         if (rdy0 !== 4'b0010) begin errors++; $display("FAIL bjp_single cyc=%0d got %b want 0010", c, rdy0); end
         if (c > 0) begin
            checks++;
            if (dut0.rr_ptr_reg !== 2'd2) begin
               errors++; $display("FAIL bjp_rrptr cyc=%0d got %0d want 2", c, dut0.rr_ptr_reg);
            end
         end
      end
   endtask

   task automatic test_reset_mid_lock;
      drv0(0, 0, 1, 1, 0, 0);
      checks++;
      if (rdy0 !== 4'b0100) begin errors++; $display("FAIL rml_start got %b want 0100", rdy0); end
      drv0(0, 0, 1, 1, 0, 0);
      checks++;
      if (locked0 !== 1'b1) begin errors++; $display("FAIL rml_locked got %b want 1", locked0); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         rst0 = 1'b1; alu0 = 1; agu0 = 1; agul0 = 1;
         #1;
         checks++;
         if (rdy0 !== 4'b0000 || locked0 !== 1'b0) begin
            errors++; $display("FAIL rml_in_reset cyc=%0d got rdy=%b locked=%b want 0000 0", c, rdy0, locked0);
         end
      end
      @(negedge clk);
      rst0 = 1'b0;
      #1;
      checks++;
      if (rdy0 !== 4'b0001 || locked0 !== 1'b0) begin
         errors++; $display("FAIL rml_after got rdy=%b locked=%b want 0001 0", rdy0, locked0);
      end
      drv0(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_timeout;
      drv1(0, 1, 1, 0);
      checks++;
      if (rdy1 !== 4'b1000) begin errors++; $display("FAIL tmo_start got %b want 1000", rdy1); end
      for (int c = 1; c <= 4; c++) begin
         drv1(1, 1, 1, 0);
         checks++;
         if (rdy1 !== 4'b1000 || locked1 !== 1'b1 || err1 !== 1'b0) begin
            errors++; $display("FAIL tmo_locked cyc=%0d got rdy=%b locked=%b err=%b want 1000 1 0", c, rdy1, locked1, err1);
         end
      end
      drv1(1, 1, 1, 0);
      checks++;
      if (rdy1 !== 4'b0001 || locked1 !== 1'b0 || err1 !== 1'b1) begin
         errors++; $display("FAIL tmo_release got rdy=%b locked=%b err=%b want 0001 0 1", rdy1, locked1, err1);
      end
      drv1(1, 1, 1, 1);
      checks++;
      if (rdy1 !== 4'b1000) begin errors++; $display("FAIL tmo_relock got %b want 1000", rdy1); end
      drv1(1, 1, 1, 0);
      checks++;
      if (err1 !== 1'b0 || locked1 !== 1'b1) begin
         errors++; $display("FAIL tmo_clr got err=%b locked=%b want 0 1", err1, locked1);
      end
      drv1(1, 1, 1, 0);
      drv1(1, 1, 1, 0);
      drv1(1, 1, 1, 1);
      checks++;
      if (rdy1 !== 4'b1000 || err1 !== 1'b0) begin
         errors++; $display("FAIL tmo_force_beat got rdy=%b err=%b want 1000 0", rdy1, err1);
      end
      drv1(0, 0, 0, 0);
      checks++;
      if (err1 !== 1'b1 || locked1 !== 1'b0) begin
         errors++; $display("FAIL tmo_set_prio got err=%b locked=%b want 1 0", err1, locked1);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_muldiv_lock();
      test_agu_bubble();
      test_single_bjp();
      test_reset_mid_lock();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exu_alu_dpath_arb.md
Name: exu_alu_dpath_arb

Overview:
- Arbiter and sequencer for the shared ALU datapath. The datapath is combinational and is shared by four requesters: ALU, BJP, AGU and MULDIV.
- Grants at most one requester per cycle and drives the one-hot datapath select lines (*_req_alu) plus the shared-buffer owner select.
- Supports multi-cycle locked ownership for MULDIV iterations and AGU AMO sequences, with a watchdog that forces a lock to release.

Parameters:
- LOCK_TIMEOUT, 64: maximum consecutive locked cycles before forced release; legal range 2..255.
- CNT_W, 8: width of the lock watchdog counter; must satisfy 2**CNT_W > LOCK_TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- alu_arb_vld  in  1  ALU requests the datapath this cycle.
- alu_arb_rdy  out  1  ALU granted; handshake = vld & rdy.
- bjp_arb_vld  in  1  BJP request.
- bjp_arb_rdy  out  1  BJP grant.
- agu_arb_vld  in  1  AGU request.
- agu_arb_lock  in  1  AGU wants to keep the datapath after this beat.
- agu_arb_rdy  out  1  AGU grant.
- muldiv_arb_vld  in  1  MULDIV request.
- muldiv_arb_lock  in  1  MULDIV wants to keep the datapath after this beat.
- muldiv_arb_rdy  out  1  MULDIV grant.
- alu_req_alu  out  1  datapath select, ALU; equals alu_arb_rdy.
- bjp_req_alu  out  1  datapath select, BJP.
- agu_req_alu  out  1  datapath select, AGU.
- muldiv_req_alu  out  1  datapath select, MULDIV; also selects the muldiv shared-buffer path.
- arb_owner  out  2  index of the current grant (0 ALU, 1 BJP, 2 AGU, 3 MULDIV); holds its last value when nothing is granted.
- arb_locked  out  1  registered lock state.
- lock_tmo_err  out  1  sticky flag: watchdog forced a release.
- lock_tmo_clr  in  1  clears lock_tmo_err.

Behaviour:
- Reset values (asynchronous, on rst=1):
  - state=ARB, rr_ptr=0, lock_owner=0, lock_cnt=0, arb_owner=0, lock_tmo_err=0.
  - All rdy and select outputs are 0 during reset.
- Grant is combinational from the current vld inputs and registered state: zero-cycle latency, because the datapath result is consumed in the same cycle.
- Exactly zero or one rdy is high per cycle. Each *_req_alu output equals the corresponding rdy. rdy never depends on the same requester's lock input.
- State ARB (arbitration):
  - Round-robin among vld requesters, starting the search at rr_ptr and wrapping 3->0.
  - On a handshake by requester i with lock=0: rr_ptr <= (i+1) mod 4; remain in ARB.
  - On a handshake by i with lock=1, only possible for AGU or MULDIV: state <= LOCKED, lock_owner <= i, lock_cnt <= 1. rr_ptr is not updated yet.
  - The ALU and BJP requesters have no lock input; they can never enter LOCKED.
- State LOCKED:
  - Only lock_owner may be granted; all other rdy are 0.
  - Owner vld=1, lock=1: grant; lock_cnt increments.
  - Owner vld=1, lock=0: grant (final beat); next state ARB; rr_ptr <= (owner+1) mod 4; lock_cnt <= 0.
  - Owner vld=0: no grant; lock is held and lock_cnt still increments. This covers stall bubbles between iterations.
  - Watchdog: when lock_cnt reaches LOCK_TIMEOUT, the next state is ARB regardless of inputs. Also rr_ptr <= (owner+1) mod 4 and lock_tmo_err <= 1.
  - The forcing cycle itself still grants the owner if it has vld=1. That beat is treated as final, even if lock=1.
- lock_tmo_err:
  - Set has priority over lock_tmo_clr when both occur in the same cycle.
  - Otherwise lock_tmo_clr=1 clears it next cycle.
- arb_locked is 1 when state==LOCKED.
- arb_owner is registered: it updates on any handshake to the granted index.
- Reset asserted mid-lock: immediate return to ARB, counters cleared, no grant while rst=1. After reset, arbitration restarts from ALU.
- The vld inputs may toggle freely. There is no requirement to hold vld until rdy, since requesters retry.
- There are no X-propagation dependencies on lock when vld=0.

Test Plan:
- Reset, then all four vld=1 with lock=0 for 4 cycles -> grants in order ALU, BJP, AGU, MULDIV (arb_owner 0,1,2,3); 5th cycle grants ALU; always exactly one rdy high.
- MULDIV vld=1, lock=1 for 33 cycles, then lock=0 on the 34th, with ALU vld=1 throughout:
  - muldiv_arb_rdy is 1 for all 34 cycles and alu_arb_rdy stays 0.
  - arb_locked=1 from cycle 2 to 34.
  - ALU is granted on cycle 35.
- AGU locks, then drops vld for 3 cycles while BJP vld=1 -> BJP stays unready, lock is held, and lock_cnt advances by 3; AGU then finishes with lock=0 -> next grant goes to MULDIV if it is requesting, else to ALU/BJP per rr_ptr=3.
- LOCK_TIMEOUT=4, MULDIV holds lock=1 forever:
  - The 4th locked cycle forces return to ARB and lock_tmo_err=1.
  - The following cycle grants another vld requester (rr_ptr=0).
  - lock_tmo_clr pulse -> err=0 next cycle; clr in the same cycle as a new timeout -> err stays 1.
- rst asserted while LOCKED with AGU as owner, deasserted 2 cycles later, with ALU and AGU vld=1 -> no rdy high during reset; first grant after reset goes to ALU; arb_locked=0.
- Single requester BJP vld=1 for 5 cycles -> granted every cycle with no idle gaps; rr_ptr stays 2 after each grant.
